// File: rtl/crossing_scheduler_if.sv
// rtl/crossing_scheduler_if.sv - request inputs and phase handshake between scheduler and sequencer
interface crossing_scheduler_if;
    logic [3:0] req_in;
    logic       phase_ack;
    logic       phase_done;
    logic       phase_req;
    logic [1:0] phase_id;
    logic [3:0] pending;
    logic       urgent;

    modport master (
        input  req_in, phase_ack, phase_done,
        output phase_req, phase_id, pending, urgent
    );

    modport slave (
        output req_in, phase_ack, phase_done,
        input  phase_req, phase_id, pending, urgent
    );
endinterface

// File: rtl/crossing_scheduler.sv
// rtl/crossing_scheduler.sv - debounced sticky requests, aged round-robin phase pick, req/ack/done handshake
module crossing_scheduler #(
    parameter int                DEBOUNCE = 2,
    parameter int                WAIT_W   = 4,
    parameter logic [WAIT_W-1:0] MAX_WAIT = 4'd12
) (
    input logic                  CLK,
    input logic                  RST,
    crossing_scheduler_if.master bus
);
    localparam int            DW      = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE);
    localparam logic [DW-1:0] DEB_ARM = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {IDLE, ARB, REQ, WAIT_DONE} state_t;
    state_t state, state_nxt;

    logic [DW-1:0]     deb_cnt [4];
    logic [WAIT_W-1:0] age     [4];
    logic [3:0]        pending;
    logic [1:0]        phase_id;
    logic [1:0]        ptr;
    logic [3:0]        aged;
    logic [3:0]        cand;
    logic [3:0]        granted;
    logic [1:0]        pick;
    logic              pick_found;
    logic              done_clr;

    assign done_clr = (state == WAIT_DONE) && bus.phase_done;

    always_comb begin
        for (int i = 0; i < 4; i++) aged[i] = (age[i] == MAX_WAIT);
    end

    // Starved sources take priority over the plain round-robin set.
    assign cand = (aged != 4'b0) ? aged : pending;

    always_comb begin
        pick       = ptr;
        pick_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!pick_found && cand[ptr + 2'(k)]) begin
                pick       = ptr + 2'(k);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        granted = 4'b0;
        if (state == REQ || state == WAIT_DONE) granted[phase_id] = 1'b1;
    end

    // Clearing the served source also drops its debounce count so it must re-qualify.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
                age[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (done_clr && phase_id == 2'(i)) begin
                    deb_cnt[i] <= '0;
                    age[i]     <= '0;
                    pending[i] <= 1'b0;
                end else begin
                    if (bus.req_in[i]) begin
                        if (deb_cnt[i] != DEB_MAX) deb_cnt[i] <= deb_cnt[i] + DW'(1);
                        if (deb_cnt[i] >= DEB_ARM) pending[i] <= 1'b1;
                    end else begin
                        deb_cnt[i] <= '0;
                    end
                    if (pending[i] && !granted[i] && age[i] != MAX_WAIT)
                        age[i] <= age[i] + WAIT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pending != 4'b0)    state_nxt = ARB;
            ARB:                               state_nxt = REQ;
            REQ:       if (bus.phase_ack)      state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.phase_done)     state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.phase_req = (state == REQ);
        bus.phase_id  = phase_id;
        bus.pending   = pending;
        bus.urgent    = |aged;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_id <= 2'd0;
            ptr      <= 2'd0;
        end else begin
            if (state == ARB) phase_id <= pick;
            if (done_clr)     ptr      <= phase_id + 2'd1;
        end
    end
endmodule

// File: tb/tb_crossing_scheduler.sv
// tb/tb_crossing_scheduler.sv - vector table, corner sequences and random run against a reference model
module tb_crossing_scheduler;
    localparam int DEB  = 2;
    localparam int MAXW = 12;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    crossing_scheduler_if bus ();

    crossing_scheduler #(.DEBOUNCE(DEB), .WAIT_W(4), .MAX_WAIT(4'd12)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference model: run lengths, sticky flags, ages and a service stage per cycle.
    int m_run [4];
    bit m_pend[4];
    int m_age [4];
    int m_phase;   // 0 idle, 1 choosing, 2 offering, 3 serving
    int m_id;
    int m_ptr;

    function automatic void chk(string name, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step(bit rst, logic [3:0] req, bit ack, bit done);
        int n_run[4];
        bit n_pend[4];
        int n_age[4];
        int cands[$];
        int best, bestd, d;
        bit in_service;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0; m_pend[i] = 0; m_age[i] = 0;
            end
            m_phase = 0; m_id = 0; m_ptr = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            in_service = (m_phase >= 2) && (m_id == i);
            n_run[i]  = req[i] ? ((m_run[i] + 1 > DEB) ? DEB : m_run[i] + 1) : 0;
            n_pend[i] = m_pend[i] || (n_run[i] == DEB);
            n_age[i]  = (m_pend[i] && !in_service) ? ((m_age[i] < MAXW) ? m_age[i] + 1 : MAXW) : m_age[i];
            if (m_phase == 3 && done && m_id == i) begin
                n_run[i] = 0; n_pend[i] = 0; n_age[i] = 0;
            end
        end
        case (m_phase)
            0: if (m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]) m_phase = 1;
            1: begin
                for (int i = 0; i < 4; i++) if (m_age[i] == MAXW) cands.push_back(i);
                if (cands.size() == 0)
                    for (int i = 0; i < 4; i++) if (m_pend[i]) cands.push_back(i);
                best = m_id; bestd = 99;
                foreach (cands[j]) begin
                    d = (cands[j] - m_ptr + 4) % 4;
                    if (d < bestd) begin bestd = d; best = cands[j]; end
                end
                m_id = best;
                m_phase = 2;
            end
            2: if (ack) m_phase = 3;
            default: if (done) begin m_ptr = (m_id + 1) % 4; m_phase = 0; end
        endcase
        for (int i = 0; i < 4; i++) begin
            m_run[i] = n_run[i]; m_pend[i] = n_pend[i]; m_age[i] = n_age[i];
        end
    endfunction

    function automatic void check_model(string tag);
        int ep, eu;
        ep = 0; eu = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i]) ep |= (1 << i);
            if (m_age[i] == MAXW) eu = 1;
        end
        chk({tag, "_req"},     int'(bus.phase_req), (m_phase == 2) ? 1 : 0);
        chk({tag, "_id"},      int'(bus.phase_id),  m_id);
        chk({tag, "_pending"}, int'(bus.pending),   ep);
        chk({tag, "_urgent"},  int'(bus.urgent),    eu);
    endfunction

    task automatic tick(input bit rst, input logic [3:0] req, input bit ack, input bit done);
        RST            = rst;
        bus.req_in     = req;
        bus.phase_ack  = ack;
        bus.phase_done = done;
        @(posedge CLK);
        model_step(rst, req, ack, done);
        #1;
        check_model("model");
    endtask

    task automatic reset_dut();
        tick(1'b1, 4'h0, 1'b0, 1'b0);
        tick(1'b1, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_grant(input string name, input int exp_id);
        int n;
        n = 0;
        while (!bus.phase_req && n < 20) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0);
            n++;
        end
        if (!bus.phase_req) chk({name, "_timeout"}, 0, 1);
        else                chk(name, int'(bus.phase_id), exp_id);
    endtask

    task automatic serve();
        tick(1'b0, 4'h0, 1'b1, 1'b0);
        tick(1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        bit         ack;
        bit         done;
        bit         e_req;
        logic [1:0] e_id;
        logic [3:0] e_pend;
        bit         e_urg;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] rq;
        bit rr, ra, rd;

        tbl[0]  = '{1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[1]  = '{1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[2]  = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[3]  = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'hF, 1'b0};
        tbl[4]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[5]  = '{1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[7]  = '{1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[8]  = '{1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 2'd0, 4'h2, 1'b0};
        tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h2, 1'b0};
        tbl[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 4'h2, 1'b0};
        tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd1, 4'h2, 1'b0};
        tbl[12] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0};
        tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0};

        for (int r = 0; r < 14; r++) begin
            tick(tbl[r].rst, tbl[r].req, tbl[r].ack, tbl[r].done);
            chk($sformatf("tbl%0d_req", r),  int'(bus.phase_req), int'(tbl[r].e_req));
            chk($sformatf("tbl%0d_id", r),   int'(bus.phase_id),  int'(tbl[r].e_id));
            chk($sformatf("tbl%0d_pend", r), int'(bus.pending),   int'(tbl[r].e_pend));
            chk($sformatf("tbl%0d_urg", r),  int'(bus.urgent),    int'(tbl[r].e_urg));
        end

        // All four pending from ptr 0: served strictly in index order.
        reset_dut();
        tick(1'b0, 4'hF, 1'b0, 1'b0);
        tick(1'b0, 4'hF, 1'b0, 1'b0);
        chk("rr_all_pending", int'(bus.pending), 4'hF);
        for (int g = 0; g < 4; g++) begin
            wait_grant($sformatf("rr_grant%0d", g), g);
            serve();
        end
        chk("rr_pending_empty", int'(bus.pending), 0);
        for (int n = 0; n < 3; n++) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0);
            chk("rr_idle_req", int'(bus.phase_req), 0);
        end

        // Long service of 0 starves 1 and 3 into urgency.
        reset_dut();
        tick(1'b0, 4'hB, 1'b0, 1'b0);
        tick(1'b0, 4'hB, 1'b0, 1'b0);
        wait_grant("age_grant0", 0);
        tick(1'b0, 4'h0, 1'b1, 1'b0);
        repeat (14) tick(1'b0, 4'h0, 1'b0, 1'b0);
        chk("age_urgent_set", int'(bus.urgent), 1);
        tick(1'b0, 4'h0, 1'b0, 1'b1);
        wait_grant("age_grant1", 1);
        serve();
        wait_grant("age_grant3", 3);
        serve();
        chk("age_urgent_clear", int'(bus.urgent), 0);
        chk("age_pending_clear", int'(bus.pending), 0);

        // DONE alongside ACK in REQ is ignored; the later DONE clears and moves ptr to 3.
        reset_dut();
        tick(1'b0, 4'h4, 1'b0, 1'b0);
        tick(1'b0, 4'h4, 1'b0, 1'b0);
        wait_grant("ackdone_grant2", 2);
        tick(1'b0, 4'h0, 1'b1, 1'b1);
        chk("ackdone_req_low", int'(bus.phase_req), 0);
        chk("ackdone_pend_kept", int'(bus.pending), 4'h4);
        tick(1'b0, 4'h0, 1'b0, 1'b1);
        chk("ackdone_pend_clear", int'(bus.pending), 0);
        tick(1'b0, 4'h9, 1'b0, 1'b0);
        tick(1'b0, 4'h9, 1'b0, 1'b0);
        wait_grant("ackdone_ptr3", 3);
        serve();
        wait_grant("ackdone_then0", 0);
        serve();

        // Reset in the middle of service.
        reset_dut();
        tick(1'b0, 4'hA, 1'b0, 1'b0);
        tick(1'b0, 4'hA, 1'b0, 1'b0);
        wait_grant("rst_grant1", 1);
        tick(1'b0, 4'h0, 1'b1, 1'b0);
        chk("rst_pend_before", int'(bus.pending), 4'hA);
        tick(1'b1, 4'h0, 1'b0, 1'b0);
        chk("rst_req", int'(bus.phase_req), 0);
        chk("rst_pend", int'(bus.pending), 0);
        chk("rst_id", int'(bus.phase_id), 0);
        tick(1'b0, 4'h0, 1'b0, 1'b1);
        chk("rst_done_ignored", int'(bus.pending), 0);
        for (int n = 0; n < 3; n++) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0);
            chk("rst_stays_idle", int'(bus.phase_req), 0);
        end

        // Random traffic, checked every cycle by the model inside tick.
        rq = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) < 3) rq[b] = $urandom_range(0, 1) == 1;
            rr = ($urandom_range(0, 199) == 0);
            ra = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 3) == 0);
            tick(rr, rq, ra, rd);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
